// File: rtl/key_debounce_fsm.sv
// Multi-key debouncer: 2-FF synchroniser plus a 4-state filter FSM per key.
// Build with KEY_LONG_PRESS_EN defined to add the key_long long-press pulse output.
module key_debounce_lane #(
   parameter int TIME_20MS = 1_000_000
`ifdef KEY_LONG_PRESS_EN
   ,parameter int TIME_LONG = 50_000_000
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic state,
   output logic press,
   output logic rls
`ifdef KEY_LONG_PRESS_EN
   ,output logic lng
`endif
);

   localparam int CW = $clog2(TIME_20MS);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIME_20MS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILTER_DN = 2'd1,
      DOWN      = 2'd2,
      FILTER_UP = 2'd3
   } st_t;

   st_t           st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    sync;
   logic          ks;
   logic          state_nxt, press_nxt, rls_nxt;

   // Synchroniser idles at 1 so a reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], key_raw};
   end

   assign ks = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st    <= IDLE;
         cnt   <= '0;
         state <= 1'b0;
         press <= 1'b0;
         rls   <= 1'b0;
      end else begin
         st    <= st_nxt;
         cnt   <= cnt_nxt;
         state <= state_nxt;
         press <= press_nxt;
         rls   <= rls_nxt;
      end
   end

   always_comb begin
      st_nxt    = st;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      rls_nxt   = 1'b0;
      unique case (st)
         IDLE: begin
            if (!ks) begin
               st_nxt  = FILTER_DN;
               cnt_nxt = '0;
            end
         end
         FILTER_DN: begin
            if (ks) begin
               st_nxt  = IDLE;
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               st_nxt    = DOWN;
               cnt_nxt   = '0;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DOWN: begin
            if (ks) begin
               st_nxt  = FILTER_UP;
               cnt_nxt = '0;
            end
         end
         FILTER_UP: begin
            if (!ks) begin
               st_nxt  = DOWN;
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               st_nxt  = IDLE;
               cnt_nxt = '0;
               rls_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
         end
      endcase
      // A key in FILTER_UP is still pressed until the release qualifies.
      state_nxt = (st_nxt == DOWN) || (st_nxt == FILTER_UP);
   end

`ifdef KEY_LONG_PRESS_EN
   localparam int LW = $clog2(TIME_LONG + 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(TIME_LONG - 1);
   localparam logic [LW-1:0] LONG_SAT  = LW'(TIME_LONG);

   logic [LW-1:0] lcnt, lcnt_nxt;
   logic          lng_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcnt <= '0;
         lng  <= 1'b0;
      end else begin
         lcnt <= lcnt_nxt;
         lng  <= lng_nxt;
      end
   end

   // Parking at LONG_SAT blocks any repeat pulse until the key leaves DOWN.
   always_comb begin
      lcnt_nxt = '0;
      lng_nxt  = 1'b0;
      if (st == DOWN && !ks) begin
         lcnt_nxt = lcnt;
         if (lcnt == LONG_LAST) begin
            lng_nxt  = 1'b1;
            lcnt_nxt = LONG_SAT;
         end else if (lcnt < LONG_LAST) begin
            lcnt_nxt = lcnt + 1'b1;
         end
      end
   end
`endif

endmodule

module key_debounce_fsm #(
   parameter int KEY_W     = 4,
   parameter int TIME_20MS = 1_000_000,
   parameter int TIME_LONG = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] key_state,
   output logic [KEY_W-1:0] key_press,
   output logic [KEY_W-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
   ,output logic [KEY_W-1:0] key_long
`endif
);

   if (TIME_20MS < 2 || TIME_LONG < 2) begin : g_bad_param
      $error("key_debounce_fsm: TIME_20MS and TIME_LONG must be >= 2");
   end

   key_debounce_lane #(
      .TIME_20MS(TIME_20MS)
`ifdef KEY_LONG_PRESS_EN
      ,.TIME_LONG(TIME_LONG)
`endif
   ) u_lane [KEY_W-1:0] (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_in),
      .state   (key_state),
      .press   (key_press),
      .rls     (key_release)
`ifdef KEY_LONG_PRESS_EN
      ,.lng    (key_long)
`endif
   );

endmodule
